// File: rtl/dac_wave_gen.sv
// Waveform sample source for a parallel DAC: hold/ramp/triangle/square codes at a programmable
// rate, offered on a valid/ready handshake with overrun flagging on consumer stalls.
module dac_wave_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] lo_code,
  input  logic [DATA_W-1:0] hi_code,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [1:0] ModeHold   = 2'd0;
  localparam logic [1:0] ModeRamp   = 2'd1;
  localparam logic [1:0] ModeTri    = 2'd2;
  localparam logic [1:0] ModeSquare = 2'd3;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dir_q, dir_d;    // 0 = up; for SQUARE, 0 = last output was lo_code
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  logic [DATA_W-1:0] p_clamp, gen_code;
  logic              gen_dir;
  logic [DATA_W:0]   sum_up, lo_step;
  logic              pending, accept, tick, start;

  // Next code from the clamped phase, using one extra bit so sums never wrap.
  always_comb begin
    gen_code = lo_code;
    gen_dir  = dir_q;
    if (phase_q < lo_code)      p_clamp = lo_code;
    else if (phase_q > hi_code) p_clamp = hi_code;
    else                        p_clamp = phase_q;
    sum_up  = {1'b0, p_clamp} + {1'b0, step};
    lo_step = {1'b0, lo_code} + {1'b0, step};
    if (lo_code < hi_code) begin
      unique case (mode)
        ModeHold: gen_code = lo_code;
        ModeRamp: gen_code = (sum_up > {1'b0, hi_code}) ? lo_code : sum_up[DATA_W-1:0];
        ModeTri: begin
          if (!dir_q) begin
            if (sum_up >= {1'b0, hi_code}) begin
              gen_code = hi_code;
              gen_dir  = 1'b1;
            end else begin
              gen_code = sum_up[DATA_W-1:0];
            end
          end else if ({1'b0, p_clamp} < lo_step) begin
            gen_code = lo_code;
            gen_dir  = 1'b0;
          end else begin
            gen_code = p_clamp - step;
          end
        end
        ModeSquare: begin
          gen_code = dir_q ? lo_code : hi_code;
          gen_dir  = ~dir_q;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    dir_d     = dir_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    tick      = 1'b0;
    start     = 1'b0;
    pending   = valid_q && !sample_ready;
    accept    = valid_q && sample_ready;

    if (accept) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          start   = 1'b1;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = pending ? StDrain : StIdle;
        end else begin
          tick  = (cnt_q >= rate_div);
          cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
      end
      StDrain: begin
        if (!pending) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      cnt_d   = '0;
      phase_d = lo_code;
      dir_d   = 1'b0;
      data_d  = lo_code;
      valid_d = 1'b1;
    end else if (tick) begin
      if (pending) begin
        // Stalled consumer: keep the offered sample and skip this period entirely.
        overrun_d = 1'b1;
      end else begin
        phase_d = gen_code;
        dir_d   = gen_dir;
        data_d  = gen_code;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      phase_q   <= '0;
      dir_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q == StRun) || valid_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen: hand-computed code sequences, stalls, drain and reset.
module tb_dac_wave_gen;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] rate_div;
  logic [15:0] step;
  logic [15:0] lo_code;
  logic [15:0] hi_code;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  dac_wave_gen #(.DATA_W(16), .DIV_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .rate_div    (rate_div),
    .step        (step),
    .lo_code     (lo_code),
    .hi_code     (hi_code),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] tri_exp [8];
  logic [15:0] sq_exp  [6];

  initial begin
    tri_exp = '{16'd0, 16'd4, 16'd8, 16'd10, 16'd6, 16'd2, 16'd0, 16'd4};
    sq_exp  = '{16'h1000, 16'hF000, 16'h1000, 16'hF000, 16'h1000, 16'hF000};

    // 1: reset held with enable high
    reset_n = 1'b0; enable = 1'b1; mode = 2'd1; rate_div = 16'd3; step = 16'd4;
    lo_code = 16'd0; hi_code = 16'd10; sample_ready = 1'b1;
    cyc(2);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    reset_n = 1'b1;
    cyc(1);
    check("idle_valid", 32'(sample_valid), 32'd0);

    // 2: RAMP 0..10 step 4, period 4
    enable = 1'b1;
    cyc(1);
    check("ramp_first_valid", 32'(sample_valid), 32'd1);
    check("ramp_first_data", 32'(sample_data), 32'd0);
    check("ramp_busy", 32'(busy), 32'd1);
    cyc(1);
    check("ramp_gap_valid", 32'(sample_valid), 32'd0);
    cyc(3);
    check("ramp_s1_valid", 32'(sample_valid), 32'd1);
    check("ramp_s1", 32'(sample_data), 32'd4);
    cyc(4);
    check("ramp_s2", 32'(sample_data), 32'd8);
    cyc(4);
    check("ramp_s3_wrap", 32'(sample_data), 32'd0);
    cyc(4);
    check("ramp_s4", 32'(sample_data), 32'd4);
    enable = 1'b0;
    cyc(1);
    check("ramp_stop_valid", 32'(sample_valid), 32'd0);
    check("ramp_stop_busy", 32'(busy), 32'd0);

    // 3: TRIANGLE, one sample per cycle
    mode = 2'd2; rate_div = 16'd0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check($sformatf("tri_s%0d", i), 32'(sample_data), 32'(tri_exp[i]));
      check($sformatf("tri_v%0d", i), 32'(sample_valid), 32'd1);
    end
    check("tri_overrun", 32'(overrun), 32'd0);
    enable = 1'b0;
    cyc(1);

    // 4: SQUARE every cycle
    mode = 2'd3; lo_code = 16'h1000; hi_code = 16'hF000; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check($sformatf("sq_s%0d", i), 32'(sample_data), 32'(sq_exp[i]));
      check($sformatf("sq_ov%0d", i), 32'(overrun), 32'd0);
    end
    enable = 1'b0;
    cyc(1);

    // 5: RAMP period 2 with stalled consumer
    mode = 2'd1; lo_code = 16'd0; hi_code = 16'd10; step = 16'd4; rate_div = 16'd1;
    sample_ready = 1'b0; enable = 1'b1;
    cyc(1);
    check("stall_e0_data", 32'(sample_data), 32'd0);
    check("stall_e0_ov", 32'(overrun), 32'd0);
    cyc(1);
    check("stall_e1_ov", 32'(overrun), 32'd0);
    cyc(1);
    check("stall_e2_ov", 32'(overrun), 32'd1);
    check("stall_e2_data", 32'(sample_data), 32'd0);
    cyc(1);
    check("stall_e3_ov", 32'(overrun), 32'd0);
    cyc(1);
    check("stall_e4_ov", 32'(overrun), 32'd1);
    check("stall_e4_data", 32'(sample_data), 32'd0);
    check("stall_e4_valid", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    cyc(1);
    check("stall_acc_valid", 32'(sample_valid), 32'd0);
    check("stall_acc_ov", 32'(overrun), 32'd0);
    cyc(1);
    check("stall_next_data", 32'(sample_data), 32'd4);
    check("stall_next_valid", 32'(sample_valid), 32'd1);

    // 6: enable drop mid-offer drains, then degenerate bounds
    sample_ready = 1'b0; enable = 1'b0;
    cyc(1);
    check("drain_valid", 32'(sample_valid), 32'd1);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_data", 32'(sample_data), 32'd4);
    cyc(1);
    check("drain2_valid", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    cyc(1);
    check("drain_done_valid", 32'(sample_valid), 32'd0);
    check("drain_done_busy", 32'(busy), 32'd0);

    lo_code = 16'h8000; hi_code = 16'h8000; mode = 2'd2; rate_div = 16'd0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check($sformatf("degen_tri%0d", i), 32'(sample_data), 32'h8000);
    end
    mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check($sformatf("degen_sq%0d", i), 32'(sample_data), 32'h8000);
    end

    // Asynchronous reset mid-offer
    sample_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(sample_valid), 32'd0);
    check("async_rst_data", 32'(sample_data), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
